// File: rtl/scan_pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pipeline_controller
//  Description : Sequencer for a stage-pipelined Canny datapath. Fills the
//                window stages in order, scans the image in a serpentine
//                raster with a staggered shift-down wave at every turn, and
//                drains the stages in order at end of image. A stall input
//                freezes the sequencer and gates all enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_pipeline_controller #(
    parameter int NUM_STAGES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stall,
    input  logic [NUM_STAGES-1:0]   fill_done,
    input  logic                    col_at_max,
    input  logic                    col_at_min,
    input  logic                    row_at_max,
    output logic [NUM_STAGES-1:0]   stage_en,
    output logic [2*NUM_STAGES-1:0] stage_mode,
    output logic                    write_enable,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_FILL = 3'd2,
        S_RUN  = 3'd3,
        S_HOLD = 3'd4,
        S_DOWN = 3'd5,
        S_END  = 3'd6
    } state_t;

    // Index of the last stage; the stage counter is wide enough for 8 stages.
    localparam logic [2:0] c_LAST  = 3'(NUM_STAGES - 1);
    localparam logic [1:0] c_RIGHT = 2'b01;
    localparam logic [1:0] c_LEFT  = 2'b10;
    localparam logic [1:0] c_DOWN  = 2'b11;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_k;
    logic [2:0]            w_k_nxt;
    logic                  r_dir_left;
    logic                  w_dir_left_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_fill_hit;
    logic                  w_turn;
    logic [1:0]            w_scan_mode;
    logic [1:0]            w_new_mode;
    logic [NUM_STAGES-1:0] w_en;
    logic [2*NUM_STAGES-1:0] w_mode;
    logic                  w_we;

    // State, stage index, direction and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= 3'd0;
            r_dir_left <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_dir_left <= w_dir_left_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state logic; a stall holds everything where it is.
    always_comb begin
        w_state_nxt    = r_state;
        w_k_nxt        = r_k;
        w_dir_left_nxt = r_dir_left;
        w_done_nxt     = 1'b0;
        w_fill_hit     = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (j == int'(r_k)) w_fill_hit = fill_done[j];
        end
        w_turn = r_dir_left ? col_at_min : col_at_max;

        if (!stall) begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_state_nxt = S_PREP;
                end
                S_PREP: begin
                    w_state_nxt    = S_FILL;
                    w_k_nxt        = 3'd0;
                    w_dir_left_nxt = 1'b0;
                end
                S_FILL: begin
                    if (w_fill_hit) begin
                        if (r_k == c_LAST) begin
                            w_state_nxt = S_RUN;
                            w_k_nxt     = 3'd0;
                        end else begin
                            w_k_nxt = r_k + 3'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_turn && row_at_max) begin
                        w_state_nxt = S_END;
                        w_k_nxt     = 3'd0;
                    end else if (w_turn) begin
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    w_state_nxt = S_DOWN;
                    w_k_nxt     = 3'd0;
                end
                S_DOWN: begin
                    if (r_k == c_LAST) begin
                        w_state_nxt    = S_RUN;
                        w_k_nxt        = 3'd0;
                        w_dir_left_nxt = ~r_dir_left;
                    end else begin
                        w_k_nxt = r_k + 3'd1;
                    end
                end
                S_END: begin
                    if (r_k == c_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_k_nxt     = 3'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_k_nxt = r_k + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_k_nxt     = 3'd0;
                end
            endcase
        end
    end

    // Moore decode of per-stage enable/mode and the write strobe.
    always_comb begin
        w_scan_mode = r_dir_left ? c_LEFT : c_RIGHT;
        w_new_mode  = r_dir_left ? c_RIGHT : c_LEFT;
        w_en        = '0;
        w_mode      = '0;
        w_we        = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            case (r_state)
                S_FILL: begin
                    if (j <= int'(r_k)) begin
                        w_en[j]          = 1'b1;
                        w_mode[2*j +: 2] = c_RIGHT;
                    end
                end
                S_RUN: begin
                    w_en[j]          = 1'b1;
                    w_mode[2*j +: 2] = w_scan_mode;
                end
                S_HOLD: begin
                    if (j != 0) begin
                        w_en[j]          = 1'b1;
                        w_mode[2*j +: 2] = w_scan_mode;
                    end
                end
                S_DOWN: begin
                    // Stages already shifted down take the new direction,
                    // the one behind the wave idles, the rest keep scanning.
                    if (j < int'(r_k)) begin
                        w_en[j]          = 1'b1;
                        w_mode[2*j +: 2] = w_new_mode;
                    end else if (j == int'(r_k)) begin
                        w_en[j]          = 1'b1;
                        w_mode[2*j +: 2] = c_DOWN;
                    end else if (j > int'(r_k) + 1) begin
                        w_en[j]          = 1'b1;
                        w_mode[2*j +: 2] = w_scan_mode;
                    end
                end
                S_END: begin
                    if (j > int'(r_k)) begin
                        w_en[j]          = 1'b1;
                        w_mode[2*j +: 2] = w_scan_mode;
                    end
                end
                default: ;
            endcase
        end
        case (r_state)
            S_RUN, S_HOLD, S_END: w_we = 1'b1;
            S_DOWN:               w_we = (r_k != c_LAST);
            default:              w_we = 1'b0;
        endcase
    end

    // Stall gates enables and the write strobe but leaves the mode decode visible.
    assign stage_en     = stall ? '0 : w_en;
    assign stage_mode   = w_mode;
    assign write_enable = w_we & ~stall;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;

endmodule
`default_nettype wire

// File: doc/scan_pipeline_controller.md
# scan_pipeline_controller

Parametrised sequencer for the stage-pipelined Canny datapath: fills NUM_STAGES window stages in order, then walks the image in a serpentine raster (right, down, left, down, ...). Each turn-around is a staggered per-stage shift-down wave, followed by an ordered drain at end of image. It generalises the fixed four-stage controller to any stage count and adds a stall input plus busy/done status. It sits between the address counters (column/row limit flags) and the per-stage window buffers and output writer.

## Interface
- NUM_STAGES, 4, number of pipelined window stages; legal 1..8; stage 0 is the first (Gaussian) stage.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- stall  in  1  freeze the sequencer and gate all activity.
- fill_done  in  NUM_STAGES  bit k: stage k's window is full.
- col_at_max  in  1  read column at right edge.
- col_at_min  in  1  read column at left edge.
- row_at_max  in  1  read row at last row.
- stage_en  out  NUM_STAGES  bit k enables stage k.
- stage_mode  out  2*NUM_STAGES  bits [2k+1:2k] are stage k's buffer mode: 00 hold, 01 shift right, 10 shift left, 11 shift down.
- write_enable  out  1  output pixel write strobe.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle frame-complete pulse.

## Operation
- States: IDLE, PREP, FILL(k), RUN, HOLD, DOWN(k), END(k). A stage index k runs 0..NUM_STAGES-1. A direction register dir holds R or L; dir is R after reset and at PREP.
- The scan mode is 01 when dir=R and 10 when dir=L.
- IDLE: all outputs 0. On start=1 and stall=0, go to PREP.
- PREP: all outputs 0. Always go to FILL(0) next.
- FILL(k): stages 0..k have en=1, mode 01; the other stages are 0/00; write_enable=0.
  - On fill_done[k], go to FILL(k+1).
  - From FILL(NUM_STAGES-1), go to RUN.
  - fill_done[j] for any j≠k is ignored.
- RUN: all stages en=1 with the scan mode; write_enable=1.
  - Turn flag: col_at_max when dir=R, col_at_min when dir=L.
  - Turn flag and row_at_max both 1: go to END(0).
  - Turn flag only: go to HOLD.
  - Otherwise stay in RUN.
- HOLD: stage 0 is 0/00; the other stages keep the old scan mode; write_enable=1. Next state is DOWN(0).
- DOWN(k):
  - stages below k: en=1, new scan mode (opposite of dir);
  - stage k: en=1, mode 11;
  - stage k+1: 0/00;
  - stages above k+1: en=1, old scan mode.
  - write_enable=1, except in DOWN(NUM_STAGES-1), where it is 0.
  - DOWN(NUM_STAGES-1) toggles dir and goes to RUN.
- END(k): stages 0..k are 0/00; the rest keep the RUN values; write_enable=1.
  - END(k) advances to END(k+1).
  - END(NUM_STAGES-1) goes to IDLE and sets done=1 for the first IDLE cycle.
- stall=1 in any non-IDLE state:
  - state, k and dir are frozen;
  - stage_en and write_enable are forced to 0;
  - stage_mode holds the frozen state's decode;
  - busy stays 1.
- stall=1 in IDLE blocks start. stall takes priority over every other input.
- NUM_STAGES=1: the FILL, DOWN and END sequences each last one state.

## Timing
- State, k, dir and done are registered. stage_en, stage_mode, write_enable and busy are a Moore decode of the registered state, gated by stall. Outputs therefore change on the same edge as the state.
- Input-to-output latency is 1 clock: inputs sampled at edge n are visible after edge n.
- Turn-around from the RUN cycle with the turn flag to the next RUN is NUM_STAGES+2 edges: HOLD, DOWN(0..N-1), RUN.
- Drain from the RUN cycle with the end condition to IDLE is NUM_STAGES+1 edges.
- rst=1 at any edge gives, after that edge:
  - state IDLE, k=0, dir=R;
  - all outputs 0, including done.
  - This applies mid-frame as well.
- start held high during a frame is ignored. A new frame needs IDLE plus start.

## Test plan
- Reset, then start with NUM_STAGES=4, pulsing fill_done[0..3] in turn.
  - Expect PREP all 0.
  - FILL(0): stage_en=0001, stage_mode[1:0]=01.
  - FILL(3): stage_en=1111, all modes 01, write_enable=0.
  - The next RUN: write_enable=1.
- RUN with dir=R and a col_at_max pulse. Expect the following, then RUN with all modes 10:
  - HOLD: stage_en=1110, stage 0 mode 00.
  - DOWN(0): stage 0 mode 11, stage 1 0/00.
  - DOWN(1)..DOWN(3) per the DOWN rule, with write_enable=0 only at DOWN(3).
- RUN with dir=L, col_at_min=1 and row_at_max=1. Expect:
  - END(0): stage_en=1110.
  - END(3): stage_en=0000, write_enable=1.
  - Then IDLE with done=1 for exactly one cycle, busy=0.
- stall=1 for 3 cycles during DOWN(1). Expect:
  - stage_en=0, write_enable=0, stage_mode unchanged;
  - the sequence resumes at DOWN(1) after stall drops.
- rst=1 during FILL(2). Expect all outputs 0 next cycle; start then re-enters PREP.
- NUM_STAGES=1 build: full fill, one turn-around and drain.
  - HOLD: stage_en=0.
  - DOWN(0): mode 11, write_enable=0.
  - END(0), then done.
